// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC bus arbiter: client indices, bus width and the
// bus-cycle state encoding.
package rtc_pkg;

    localparam int unsigned RTC_AW   = 8;
    localparam int unsigned N_CLI    = 3;
    localparam int unsigned CLI_INIT = 0;
    localparam int unsigned CLI_USER = 1;
    localparam int unsigned CLI_POLL = 2;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAddrSet = 3'd1,
        StAddrStb = 3'd2,
        StAddrHld = 3'd3,
        StDataSet = 3'd4,
        StDataStb = 3'd5,
        StDataHld = 3'd6,
        StDone    = 3'd7
    } rtc_state_e;

    // Successor of each timed phase; non-phase states map back to idle.
    function automatic rtc_state_e next_phase(input rtc_state_e s);
        rtc_state_e n;
        case (s)
            StAddrSet: n = StAddrStb;
            StAddrStb: n = StAddrHld;
            StAddrHld: n = StDataSet;
            StDataSet: n = StDataStb;
            StDataStb: n = StDataHld;
            StDataHld: n = StDone;
            default:   n = StIdle;
        endcase
        return n;
    endfunction

    // Fixed priority: init > user > poll.
    function automatic logic [N_CLI-1:0] prio_pick(input logic [N_CLI-1:0] r);
        logic [N_CLI-1:0] p;
        p = '0;
        if (r[CLI_INIT]) begin
            p[CLI_INIT] = 1'b1;
        end else if (r[CLI_USER]) begin
            p[CLI_USER] = 1'b1;
        end else if (r[CLI_POLL]) begin
            p[CLI_POLL] = 1'b1;
        end
        return p;
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Phase timer: down-counter reloaded with PHASE_CYC-1 on every phase entry; tc marks the
// last cycle of the current phase.
module rtc_phase_timer #(
    parameter int unsigned PHASE_CYC = 4
) (
    input  logic CLK,
    input  logic reset,
    input  logic load,
    output logic tc
);

    localparam int unsigned CW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(PHASE_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Arbitrates three RTC sub-controllers onto the multiplexed RTC bus and sequences the
// address-phase / data-phase strobes for one byte transfer per grant.
module rtc_bus_arbiter
    import rtc_pkg::*;
#(
    parameter int unsigned PHASE_CYC = 4
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic [N_CLI-1:0]        req,
    input  logic [N_CLI-1:0]        wr,
    input  logic [N_CLI*RTC_AW-1:0] addr,
    input  logic [N_CLI*RTC_AW-1:0] wdata,
    output logic [N_CLI-1:0]        gnt,
    output logic [N_CLI-1:0]        done,
    output logic [RTC_AW-1:0]       rdata,
    output logic                    busy,
    output logic                    rtc_cs_n,
    output logic                    rtc_rd_n,
    output logic                    rtc_wr_n,
    output logic                    rtc_ad,
    output logic [RTC_AW-1:0]       rtc_ad_out,
    output logic                    rtc_ad_oe,
    input  logic [RTC_AW-1:0]       rtc_ad_in
);

    rtc_state_e        state_q, state_d;
    logic [N_CLI-1:0]  own_q, own_d;
    logic              wr_q, wr_d;
    logic [RTC_AW-1:0] addr_q, addr_d;
    logic [RTC_AW-1:0] wdata_q, wdata_d;
    logic              load, tc;

    logic [N_CLI-1:0]  gnt_d, done_d;
    logic              busy_d, cs_n_d, rd_n_d, wr_n_d, ad_d, oe_d;
    logic [RTC_AW-1:0] ad_out_d;

    rtc_phase_timer #(
        .PHASE_CYC (PHASE_CYC)
    ) u_phase_timer (
        .CLK   (CLK),
        .reset (reset),
        .load  (load),
        .tc    (tc)
    );

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    own_d = prio_pick(req);
                    for (int i = 0; i < N_CLI; i++) begin
                        if (own_d[i]) begin
                            wr_d    = wr[i];
                            addr_d  = addr[RTC_AW*i +: RTC_AW];
                            wdata_d = wdata[RTC_AW*i +: RTC_AW];
                        end
                    end
                    state_d = StAddrSet;
                    load    = 1'b1;
                end
            end
            StDone: state_d = StIdle;
            default: begin
                if (tc) begin
                    state_d = next_phase(state_q);
                    load    = 1'b1;
                end
            end
        endcase
    end

    // Pin values are decoded from the next state so every output comes straight from a flop.
    always_comb begin
        gnt_d    = '0;
        done_d   = '0;
        busy_d   = 1'b0;
        cs_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        ad_d     = 1'b0;
        oe_d     = 1'b0;
        ad_out_d = '0;
        unique case (state_d)
            StIdle: ;
            StAddrSet, StAddrStb, StAddrHld: begin
                gnt_d    = own_d;
                busy_d   = 1'b1;
                oe_d     = 1'b1;
                ad_out_d = addr_d;
                if (state_d == StAddrStb) begin
                    cs_n_d = 1'b0;
                    wr_n_d = 1'b0;
                end
            end
            StDataSet, StDataStb, StDataHld, StDone: begin
                gnt_d    = own_d;
                busy_d   = 1'b1;
                ad_d     = 1'b1;
                oe_d     = wr_d;
                ad_out_d = wr_d ? wdata_d : '0;
                if (state_d == StDataStb) begin
                    cs_n_d = 1'b0;
                    wr_n_d = ~wr_d;
                    rd_n_d = wr_d;
                end
                if (state_d == StDone) begin
                    done_d = own_d;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= StIdle;
            own_q      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            gnt        <= '0;
            done       <= '0;
            rdata      <= '0;
            busy       <= 1'b0;
            rtc_cs_n   <= 1'b1;
            rtc_rd_n   <= 1'b1;
            rtc_wr_n   <= 1'b1;
            rtc_ad     <= 1'b0;
            rtc_ad_oe  <= 1'b0;
            rtc_ad_out <= '0;
        end else begin
            state_q    <= state_d;
            own_q      <= own_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            gnt        <= gnt_d;
            done       <= done_d;
            busy       <= busy_d;
            rtc_cs_n   <= cs_n_d;
            rtc_rd_n   <= rd_n_d;
            rtc_wr_n   <= wr_n_d;
            rtc_ad     <= ad_d;
            rtc_ad_oe  <= oe_d;
            rtc_ad_out <= ad_out_d;
            // Sample the bus at the end of the read strobe.
            if (state_q == StDataStb && tc && !wr_q) begin
                rdata <= rtc_ad_in;
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Self-checking bench for rtc_bus_arbiter: cycle-accurate pin model plus a scoreboard of
// expected done/rdata per granted transfer.
module tb_rtc_bus_arbiter;

    logic        CLK = 1'b0;
    logic        reset;
    logic [2:0]  req, wr, gnt, done;
    logic [23:0] addr, wdata;
    logic [7:0]  rdata, rtc_ad_out, rtc_ad_in;
    logic        busy, rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad, rtc_ad_oe;

    logic [2:0]  req1, wr1, gnt1, done1;
    logic [23:0] addr1, wdata1;
    logic [7:0]  rdata1, rtc_ad_out1, rtc_ad_in1;
    logic        busy1, rtc_cs_n1, rtc_rd_n1, rtc_wr_n1, rtc_ad1, rtc_ad_oe1;

    always #5 CLK = ~CLK;

    rtc_bus_arbiter #(.PHASE_CYC(2)) dut (
        .CLK(CLK), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .busy(busy), .rtc_cs_n(rtc_cs_n),
        .rtc_rd_n(rtc_rd_n), .rtc_wr_n(rtc_wr_n), .rtc_ad(rtc_ad), .rtc_ad_out(rtc_ad_out),
        .rtc_ad_oe(rtc_ad_oe), .rtc_ad_in(rtc_ad_in)
    );

    rtc_bus_arbiter #(.PHASE_CYC(1)) dut1 (
        .CLK(CLK), .reset(reset), .req(req1), .wr(wr1), .addr(addr1), .wdata(wdata1),
        .gnt(gnt1), .done(done1), .rdata(rdata1), .busy(busy1), .rtc_cs_n(rtc_cs_n1),
        .rtc_rd_n(rtc_rd_n1), .rtc_wr_n(rtc_wr_n1), .rtc_ad(rtc_ad1),
        .rtc_ad_out(rtc_ad_out1), .rtc_ad_oe(rtc_ad_oe1), .rtc_ad_in(rtc_ad_in1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic       busy;
        logic       cs_n;
        logic       rd_n;
        logic       wr_n;
        logic       oe;
        logic [7:0] out;
        logic       dn;
    } pins_t;

    typedef struct {
        logic [2:0] own;
        logic       w;
        logic [7:0] rd;
    } sb_t;

    sb_t sb[$];

    // Expected pins k cycles after the sampling IDLE cycle of a transfer.
    function automatic pins_t exp_pins(int p, int k, logic w, logic [7:0] a, logic [7:0] d);
        pins_t e;
        int    ph;
        e.busy = 1'b0; e.cs_n = 1'b1; e.rd_n = 1'b1; e.wr_n = 1'b1;
        e.oe = 1'b0; e.out = 8'h00; e.dn = 1'b0;
        if (k >= 1 && k <= 6 * p) begin
            ph = (k - 1) / p;
            e.busy = 1'b1;
            if (ph < 3) begin
                e.oe = 1'b1;
                e.out = a;
                if (ph == 1) begin e.cs_n = 1'b0; e.wr_n = 1'b0; end
            end else begin
                e.oe = w;
                e.out = w ? d : 8'h00;
                if (ph == 4) begin
                    e.cs_n = 1'b0;
                    if (w) e.wr_n = 1'b0;
                    else e.rd_n = 1'b0;
                end
            end
        end else if (k == 6 * p + 1) begin
            e.busy = 1'b1; e.oe = w; e.out = w ? d : 8'h00; e.dn = 1'b1;
        end
        return e;
    endfunction

    function automatic logic exp_ad(int p, int k);
        return (k > 3 * p) && (k <= 6 * p);
    endfunction

    function automatic logic [2:0] exp_gnt(int p, int k, logic [2:0] own);
        return (k >= 1 && k <= 6 * p + 1) ? own : 3'b000;
    endfunction

    function automatic pins_t obs0();
        pins_t o;
        o.busy = busy; o.cs_n = rtc_cs_n; o.rd_n = rtc_rd_n; o.wr_n = rtc_wr_n;
        o.oe = rtc_ad_oe; o.out = rtc_ad_out; o.dn = |done;
        return o;
    endfunction

    function automatic pins_t obs1();
        pins_t o;
        o.busy = busy1; o.cs_n = rtc_cs_n1; o.rd_n = rtc_rd_n1; o.wr_n = rtc_wr_n1;
        o.oe = rtc_ad_oe1; o.out = rtc_ad_out1; o.dn = |done1;
        return o;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_cmp++;
        if ({gnt, done, rdata, busy, rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad, rtc_ad_oe, rtc_ad_out}
            !== {3'b0, 3'b0, 8'h00, 1'b0, 3'b111, 1'b0, 1'b0, 8'h00}) begin
            n_bad++;
            $display("FAIL reset_state: got gnt=%b done=%b rdata=%h busy=%b cs/rd/wr=%b%b%b ad=%b oe=%b out=%h, want all idle/zero with strobes 1",
                     gnt, done, rdata, busy, rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad, rtc_ad_oe, rtc_ad_out);
        end
        n_cmp++;
        if ({gnt1, done1, rdata1, busy1, rtc_cs_n1, rtc_rd_n1, rtc_wr_n1, rtc_ad1, rtc_ad_oe1,
             rtc_ad_out1} !== {3'b0, 3'b0, 8'h00, 1'b0, 3'b111, 1'b0, 1'b0, 8'h00}) begin
            n_bad++;
            $display("FAIL reset_state_p1: got busy=%b cs/rd/wr=%b%b%b oe=%b, want idle",
                     busy1, rtc_cs_n1, rtc_rd_n1, rtc_wr_n1, rtc_ad_oe1);
        end
        reset = 1'b0;
        step();
        n_cmp++;
        if (busy !== 1'b0 || gnt !== 3'b000) begin
            n_bad++;
            $display("FAIL idle_after_reset: busy=%b gnt=%b, want 0/000", busy, gnt);
        end
    endtask

    task automatic test_single_write();
        pins_t e, o;
        sb_t   s;
        req = 3'b001; wr = 3'b001; addr[7:0] = 8'h21; wdata[7:0] = 8'h5A;
        sb.push_back('{own: 3'b001, w: 1'b1, rd: 8'h00});
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 1) req = 3'b000;
            e = exp_pins(2, k, 1'b1, 8'h21, 8'h5A);
            o = obs0();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL write_pins c%0d: got %h want %h", k, o, e);
            end
            n_cmp++;
            if (gnt !== exp_gnt(2, k, 3'b001)) begin
                n_bad++;
                $display("FAIL write_gnt c%0d: got %b want %b", k, gnt, exp_gnt(2, k, 3'b001));
            end
            if (k != 13) begin
                n_cmp++;
                if (rtc_ad !== exp_ad(2, k)) begin
                    n_bad++;
                    $display("FAIL write_ad c%0d: got %b want %b", k, rtc_ad, exp_ad(2, k));
                end
            end
            if (done !== 3'b000) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL write_done c%0d: done=%b with nothing pending", k, done);
                end else begin
                    s = sb.pop_front();
                    if (done !== s.own) begin
                        n_bad++;
                        $display("FAIL write_done c%0d: got %b want %b", k, done, s.own);
                    end
                end
            end
        end
    endtask

    task automatic test_read();
        pins_t e, o;
        sb_t   s;
        rtc_ad_in = 8'hEE;
        req = 3'b100; wr = 3'b000; addr[23:16] = 8'h22;
        sb.push_back('{own: 3'b100, w: 1'b0, rd: 8'h47});
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 1) req = 3'b000;
            rtc_ad_in = (k == 9 || k == 10) ? 8'h47 : 8'hEE;
            e = exp_pins(2, k, 1'b0, 8'h22, 8'h00);
            o = obs0();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL read_pins c%0d: got %h want %h", k, o, e);
            end
            n_cmp++;
            if (gnt !== exp_gnt(2, k, 3'b100)) begin
                n_bad++;
                $display("FAIL read_gnt c%0d: got %b want %b", k, gnt, exp_gnt(2, k, 3'b100));
            end
            if (done !== 3'b000) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL read_done c%0d: done=%b with nothing pending", k, done);
                end else begin
                    s = sb.pop_front();
                    if (done !== s.own || rdata !== s.rd) begin
                        n_bad++;
                        $display("FAIL read_done c%0d: got done=%b rdata=%h want %b %h",
                                 k, done, rdata, s.own, s.rd);
                    end
                end
            end
        end
        rtc_ad_in = 8'h99;
        for (int k = 0; k < 3; k++) step();
        n_cmp++;
        if (rdata !== 8'h47) begin
            n_bad++;
            $display("FAIL read_hold: rdata got %h want 47", rdata);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] aa[3], dd[3];
        logic       ww[3];
        pins_t      e, o;
        sb_t        s;
        int         j, kk;
        aa = '{8'h10, 8'h11, 8'h12};
        dd = '{8'hA0, 8'hB1, 8'hC2};
        ww = '{1'b1, 1'b0, 1'b1};
        rtc_ad_in = 8'h33;
        req = 3'b111; wr = 3'b101;
        addr = {aa[2], aa[1], aa[0]}; wdata = {dd[2], dd[1], dd[0]};
        sb.push_back('{own: 3'b001, w: 1'b1, rd: 8'h00});
        sb.push_back('{own: 3'b010, w: 1'b0, rd: 8'h33});
        sb.push_back('{own: 3'b100, w: 1'b1, rd: 8'h00});
        for (int k = 1; k <= 42; k++) begin
            step();
            j = (k - 1) / 14;
            kk = k - 14 * j;
            e = exp_pins(2, kk, ww[j], aa[j], dd[j]);
            o = obs0();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL simul_pins c%0d: got %h want %h", k, o, e);
            end
            n_cmp++;
            if (gnt !== exp_gnt(2, kk, 3'b001 << j)) begin
                n_bad++;
                $display("FAIL simul_gnt c%0d: got %b want %b", k, gnt, exp_gnt(2, kk, 3'b001 << j));
            end
            if (done !== 3'b000) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL simul_done c%0d: done=%b with nothing pending", k, done);
                end else begin
                    s = sb.pop_front();
                    if (done !== s.own || (!s.w && rdata !== s.rd)) begin
                        n_bad++;
                        $display("FAIL simul_done c%0d: got done=%b rdata=%h want %b %h",
                                 k, done, rdata, s.own, s.rd);
                    end
                end
            end
            if (kk == 13) req[j] = 1'b0;
        end
    endtask

    task automatic test_mid_change();
        pins_t e, o;
        sb_t   s;
        req = 3'b010; wr = 3'b010; addr[15:8] = 8'h31; wdata[15:8] = 8'h77;
        sb.push_back('{own: 3'b010, w: 1'b1, rd: 8'h00});
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 9) begin
                req = 3'b000; wr = 3'b000; addr[15:8] = 8'hFF; wdata[15:8] = 8'h00;
            end
            e = exp_pins(2, k, 1'b1, 8'h31, 8'h77);
            o = obs0();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL midchg_pins c%0d: got %h want %h", k, o, e);
            end
            if (done !== 3'b000) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL midchg_done c%0d: done=%b with nothing pending", k, done);
                end else begin
                    s = sb.pop_front();
                    if (done !== s.own) begin
                        n_bad++;
                        $display("FAIL midchg_done c%0d: got %b want %b", k, done, s.own);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        pins_t e, o;
        sb_t   s;
        int    seen;
        req = 3'b001; wr = 3'b001; addr[7:0] = 8'h44; wdata[7:0] = 8'h55;
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k == 1) req = 3'b000;
            e = exp_pins(2, k, 1'b1, 8'h44, 8'h55);
            o = obs0();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL rstmid_pre c%0d: got %h want %h", k, o, e);
            end
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++;
        if ({rtc_cs_n, rtc_rd_n, rtc_wr_n, gnt, done, busy, rdata} !== {3'b111, 3'b0, 3'b0, 1'b0, 8'h00}) begin
            n_bad++;
            $display("FAIL rstmid_abort: cs/rd/wr=%b%b%b gnt=%b done=%b busy=%b rdata=%h, want 111 000 000 0 00",
                     rtc_cs_n, rtc_rd_n, rtc_wr_n, gnt, done, busy, rdata);
        end
        seen = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (done !== 3'b000 || busy !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL rstmid_quiet: %0d cycles with done/busy active, want 0", seen);
        end
        rtc_ad_in = 8'h5C;
        req = 3'b100; wr = 3'b000; addr[23:16] = 8'h66;
        sb.push_back('{own: 3'b100, w: 1'b0, rd: 8'h5C});
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 1) req = 3'b000;
            e = exp_pins(2, k, 1'b0, 8'h66, 8'h00);
            o = obs0();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL rstmid_post c%0d: got %h want %h", k, o, e);
            end
            if (done !== 3'b000) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL rstmid_done c%0d: done=%b with nothing pending", k, done);
                end else begin
                    s = sb.pop_front();
                    if (done !== s.own || rdata !== s.rd) begin
                        n_bad++;
                        $display("FAIL rstmid_done c%0d: got done=%b rdata=%h want %b %h",
                                 k, done, rdata, s.own, s.rd);
                    end
                end
            end
        end
    endtask

    task automatic test_phase1();
        pins_t e, o;
        sb_t   s;
        req1 = 3'b010; wr1 = 3'b010; addr1[15:8] = 8'h13; wdata1[15:8] = 8'hB1;
        sb.push_back('{own: 3'b010, w: 1'b1, rd: 8'h00});
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1) req1 = 3'b000;
            e = exp_pins(1, k, 1'b1, 8'h13, 8'hB1);
            o = obs1();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL p1_pins c%0d: got %h want %h", k, o, e);
            end
            n_cmp++;
            if (gnt1 !== exp_gnt(1, k, 3'b010)) begin
                n_bad++;
                $display("FAIL p1_gnt c%0d: got %b want %b", k, gnt1, exp_gnt(1, k, 3'b010));
            end
            if (done1 !== 3'b000) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL p1_done c%0d: done=%b with nothing pending", k, done1);
                end else begin
                    s = sb.pop_front();
                    if (done1 !== s.own) begin
                        n_bad++;
                        $display("FAIL p1_done c%0d: got %b want %b", k, done1, s.own);
                    end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        req = '0; wr = '0; addr = '0; wdata = '0; rtc_ad_in = '0;
        req1 = '0; wr1 = '0; addr1 = '0; wdata1 = '0; rtc_ad_in1 = '0;
        test_reset();
        test_single_write();
        test_read();
        test_simultaneous();
        test_mid_change();
        test_reset_mid();
        test_phase1();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d transfers never completed, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
